scope_frame_tx: RTL and testbench

Capture/packetize stage directly upstream of the UART transmitter. On arm, waits for a level trigger on the ADC sample stream, stores DEPTH consecutive samples in an on-chip buffer, then streams a framed packet (header, samples, checksum) one byte at a time. Each byte is handed over via the transmitter's byte-strobe interface (tx_data + active-low tx_int), and the next byte is paced by the transmitter's bps_start activity flag.

---
 rtl/scope_frame_tx_pkg.sv | 29 ++
 rtl/scope_frame_tx_if.sv | 10 +
 rtl/scope_sample_ram.sv | 25 ++
 rtl/scope_frame_tx.sv | 157 +++++++++++++++
 tb/tb_scope_frame_tx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scope_frame_tx_pkg.sv
// Shared constants for the scope capture/packetize stage: default header bytes,
// FSM state encodings and the trigger crossing rule (also used by host-side models).
package scope_frame_tx_pkg;

    localparam logic [7:0] HDR0_DEF = 8'hA5;
    localparam logic [7:0] HDR1_DEF = 8'h5A;

    // REQ/ACK/FIN are the per-byte sub-phases of SEND.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_TRIG = 3'd1;
    localparam logic [2:0] ST_CAPTURE   = 3'd2;
    localparam logic [2:0] ST_REQ       = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_FIN       = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    // Level crossing between the previous and the current sample.
    function automatic logic level_cross(
        input logic [7:0] prev,
        input logic [7:0] cur,
        input logic [7:0] level,
        input logic       rise
    );
        if (rise)
            return (prev < level) && (cur >= level);
        return (prev > level) && (cur <= level);
    endfunction

endpackage

// File: rtl/scope_frame_tx_if.sv
// Byte-strobe link to the UART transmitter: byte + active-low request out,
// transmitter activity flag (bps_start) back.
interface scope_frame_tx_if;
    logic [7:0] tx_data;
    logic       tx_int;
    logic       tx_busy;

    modport master (output tx_data, output tx_int, input tx_busy);
    modport slave  (input tx_data, input tx_int, output tx_busy);
endinterface

// File: rtl/scope_sample_ram.sv
// Simple dual-port sample buffer, one write and one registered read port on clk,
// shaped so the tools map it onto block RAM.
module scope_sample_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; a reset branch would stop block-RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/scope_frame_tx.sv
// Scope capture/packetize stage: level trigger on the ADC stream, DEPTH-sample
// capture, then HDR0, HDR1, samples, checksum streamed byte-by-byte to the UART.
module scope_frame_tx
    import scope_frame_tx_pkg::*;
#(
    parameter int         DEPTH  = 256,
    parameter int         ADDR_W = 8,
    parameter logic [7:0] HDR0   = HDR0_DEF,
    parameter logic [7:0] HDR1   = HDR1_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              adc_data,
    input  logic                    adc_valid,
    input  logic [7:0]              trig_level,
    input  logic                    trig_rise,
    input  logic                    force_trig,
    input  logic                    arm,
    scope_frame_tx_if.master        tx,
    output logic                    busy,
    output logic                    done
);

    localparam int CNT_W = ADDR_W + 2;
    localparam logic [CNT_W-1:0]  FRAME_LEN  = CNT_W'(DEPTH + 3);
    localparam logic [ADDR_W:0]   LAST_WADDR = (ADDR_W + 1)'(DEPTH - 1);

    logic [2:0]        state;
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic [CNT_W-1:0]  byte_cnt;
    logic [7:0]        checksum;
    logic [7:0]        prev_sample;
    logic              prev_valid;
    logic [7:0]        rd_data;
    logic              trig_now;
    logic              wr_en;
    logic              sample_phase;
    logic [7:0]        next_byte;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        trig_now = 1'b0;
        wr_en    = 1'b0;
        if (state == ST_WAIT_TRIG && adc_valid && prev_valid && !force_trig)
            trig_now = level_cross(prev_sample, adc_data, trig_level, trig_rise);
        if (adc_valid && (state == ST_CAPTURE || trig_now))
            wr_en = 1'b1;
    end

    // rptr reaching DEPTH marks that every sample byte has been sent.
    always_comb begin
        sample_phase = 1'b0;
        next_byte    = checksum;
        if (byte_cnt == '0)
            next_byte = HDR0;
        else if (byte_cnt == CNT_W'(1))
            next_byte = HDR1;
        else if (!rptr[ADDR_W]) begin
            sample_phase = 1'b1;
            next_byte    = rd_data;
        end
    end

    // wptr is 0 in WAIT_TRIG, so the triggering sample lands at index 0.
    scope_sample_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wptr[ADDR_W-1:0]),
        .wr_data (adc_data),
        .rd_addr (rptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wptr        <= '0;
            rptr        <= '0;
            byte_cnt    <= '0;
            checksum    <= '0;
            prev_sample <= '0;
            prev_valid  <= 1'b0;
            tx.tx_data  <= '0;
            tx.tx_int   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        state      <= ST_WAIT_TRIG;
                        wptr       <= '0;
                        rptr       <= '0;
                        byte_cnt   <= '0;
                        checksum   <= '0;
                        prev_valid <= 1'b0;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (force_trig) begin
                        state <= ST_CAPTURE;
                        wptr  <= '0;
                    end else if (adc_valid) begin
                        prev_sample <= adc_data;
                        prev_valid  <= 1'b1;
                        if (trig_now) begin
                            state <= ST_CAPTURE;
                            wptr  <= (ADDR_W + 1)'(1);
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (adc_valid) begin
                        wptr <= wptr + 1'b1;
                        if (wptr == LAST_WADDR) begin
                            // Enter via FIN so a transmitter that is still busy is waited out.
                            state    <= ST_FIN;
                            rptr     <= '0;
                            byte_cnt <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    tx.tx_data <= next_byte;
                    tx.tx_int  <= 1'b0;
                    if (sample_phase) begin
                        checksum <= checksum + rd_data;
                        rptr     <= rptr + 1'b1;
                    end
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    if (tx.tx_busy) begin
                        tx.tx_int <= 1'b1;
                        byte_cnt  <= byte_cnt + 1'b1;
                        state     <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    if (!tx.tx_busy)
                        state <= (byte_cnt == FRAME_LEN) ? ST_DONE : ST_REQ;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE) && (state != ST_DONE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_scope_frame_tx.sv
// Directed bench for scope_frame_tx (DEPTH=8): ADC ramp source, UART transmitter
// model with programmable bps_start delay/length, per-byte frame checks.
module tb_scope_frame_tx;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int FLEN   = DEPTH + 3;

    typedef logic [7:0] frame_t [FLEN];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] adc_data;
    logic       adc_valid;
    logic [7:0] trig_level;
    logic       trig_rise;
    logic       force_trig;
    logic       arm;
    logic       busy;
    logic       done;

    scope_frame_tx_if tx_if ();

    scope_frame_tx #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .HDR0   (8'hA5),
        .HDR1   (8'h5A)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .trig_level (trig_level),
        .trig_rise  (trig_rise),
        .force_trig (force_trig),
        .arm        (arm),
        .tx         (tx_if),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ADC source settings (written by the main sequence while adc_en = 0)
    bit         adc_en   = 1'b0;
    logic [7:0] adc_next = 8'h00;
    logic [7:0] adc_step = 8'h00;

    // Transmitter model settings and observations
    bit         force_busy = 1'b0;
    int         tx_delay   = 10;
    int         tx_len     = 50;
    int         req_cnt    = 0;
    int         stab_err   = 0;
    logic [7:0] rx_q [$];

    int  fall_busy_err = 0;
    int  done_cnt      = 0;
    int  done_wide_err = 0;
    bit  done_prev     = 1'b0;

    const frame_t ramp_up = '{8'hA5, 8'h5A, 8'h80, 8'h88, 8'h90, 8'h98,
                              8'hA0, 8'hA8, 8'hB0, 8'hB8, 8'hE0};
    const frame_t ramp_dn = '{8'hA5, 8'h5A, 8'h40, 8'h38, 8'h30, 8'h28,
                              8'h20, 8'h18, 8'h10, 8'h08, 8'h20};
    const frame_t flat_10 = '{8'hA5, 8'h5A, 8'h10, 8'h10, 8'h10, 8'h10,
                              8'h10, 8'h10, 8'h10, 8'h10, 8'h80};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ADC: one valid sample every 4 clocks while enabled
    initial begin
        int div;
        div       = 0;
        adc_valid = 1'b0;
        adc_data  = 8'h00;
        forever begin
            @(negedge clk);
            adc_valid = 1'b0;
            if (!adc_en) begin
                div = 0;
            end else if (div == 3) begin
                div       = 0;
                adc_valid = 1'b1;
                adc_data  = adc_next;
                adc_next  = adc_next + adc_step;
            end else begin
                div++;
            end
        end
    end

    // Transmitter: bps_start rises tx_delay cycles after a request, stays tx_len cycles
    initial begin
        logic [7:0] held;
        bit         live;
        tx_if.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (force_busy) begin
                tx_if.tx_busy = 1'b1;
            end else if (rst_n === 1'b1 && tx_if.tx_int === 1'b0 && !tx_if.tx_busy) begin
                held = tx_if.tx_data;
                live = 1'b1;
                rx_q.push_back(held);
                req_cnt++;
                for (int i = 0; i < tx_delay; i++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) live = 1'b0;
                    if (live && tx_if.tx_data !== held) stab_err++;
                end
                tx_if.tx_busy = 1'b1;
                for (int i = 0; i < tx_len; i++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) live = 1'b0;
                    if (live && tx_if.tx_data !== held) stab_err++;
                end
                tx_if.tx_busy = 1'b0;
            end else begin
                tx_if.tx_busy = 1'b0;
            end
        end
    end

    always @(negedge tx_if.tx_int)
        if (tx_if.tx_busy === 1'b1) fall_busy_err++;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (done_prev) done_wide_err++;
        end
        done_prev = (done === 1'b1);
    end

    task automatic pulse_arm();
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
    endtask

    task automatic start_frame(input string tag, input logic [7:0] lvl, input logic rise,
                               input logic [7:0] start, input logic [7:0] step, input bit force_it,
                               output int q_base, output int r_base, output int d_base);
        adc_en     = 1'b0;
        trig_level = lvl;
        trig_rise  = rise;
        adc_next   = start;
        adc_step   = step;
        q_base     = rx_q.size();
        r_base     = req_cnt;
        d_base     = done_cnt;
        pulse_arm();
        if (force_it) begin
            force_trig = 1'b1;
            @(negedge clk) force_trig = 1'b0;
        end
        check({tag, "_busy_after_arm"}, busy, 1'b1);
        adc_en = 1'b1;
    endtask

    task automatic wait_req(input string tag, input int n, input int budget);
        int i = 0;
        while (req_cnt < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_req_timeout"}, req_cnt >= n, 1'b1);
    endtask

    task automatic finish_frame(input string tag, input frame_t exp, input int budget,
                                input int q_base, input int r_base, input int d_base);
        int         i = 0;
        logic [31:0] got;
        while (done_cnt == d_base && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_done_timeout"}, done_cnt > d_base, 1'b1);
        adc_en = 1'b0;
        repeat (30) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - d_base, 1);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_req_count"}, req_cnt - r_base, FLEN);
        for (int k = 0; k < FLEN; k++) begin
            got = (q_base + k < rx_q.size()) ? 32'(rx_q[q_base + k]) : 32'hDEAD;
            check($sformatf("%s_byte%0d", tag, k), got, 32'(exp[k]));
        end
    endtask

    initial begin
        int qb, rb, db;
        rst_n      = 1'b0;
        arm        = 1'b0;
        force_trig = 1'b0;
        trig_level = 8'h00;
        trig_rise  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_int", tx_if.tx_int, 1'b1);
        check("rst_tx_data", tx_if.tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Rising trigger at 0x80 on an upward ramp
        start_frame("t1", 8'h80, 1'b1, 8'h70, 8'h08, 1'b0, qb, rb, db);
        finish_frame("t1", ramp_up, 3000, qb, rb, db);

        // Falling trigger at 0x40 on a downward ramp
        start_frame("t2", 8'h40, 1'b0, 8'h50, 8'hF8, 1'b0, qb, rb, db);
        finish_frame("t2", ramp_dn, 3000, qb, rb, db);

        // Forced trigger on a constant input
        start_frame("t3", 8'hFF, 1'b1, 8'h10, 8'h00, 1'b1, qb, rb, db);
        finish_frame("t3", flat_10, 3000, qb, rb, db);

        // Transmitter busy before SEND, then slow bps_start per byte
        force_busy = 1'b1;
        start_frame("t4", 8'h80, 1'b1, 8'h70, 8'h08, 1'b0, qb, rb, db);
        repeat (120) @(negedge clk);
        check("t4_no_req_while_busy", req_cnt - rb, 0);
        check("t4_tx_int_idle", tx_if.tx_int, 1'b1);
        tx_delay   = 100;
        force_busy = 1'b0;
        finish_frame("t4", ramp_up, 6000, qb, rb, db);
        tx_delay = 10;

        // arm during CAPTURE and during SEND is ignored
        start_frame("t5", 8'h80, 1'b1, 8'h70, 8'h08, 1'b0, qb, rb, db);
        repeat (24) @(negedge clk);
        pulse_arm();
        wait_req("t5", rb + 3, 2000);
        pulse_arm();
        finish_frame("t5", ramp_up, 3000, qb, rb, db);

        // Reset during the fifth byte, then a clean frame
        start_frame("t6a", 8'h80, 1'b1, 8'h70, 8'h08, 1'b0, qb, rb, db);
        wait_req("t6", rb + 5, 3000);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("t6_rst_tx_int", tx_if.tx_int, 1'b1);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_done", done, 1'b0);
        adc_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        start_frame("t6", 8'h80, 1'b1, 8'h70, 8'h08, 1'b0, qb, rb, db);
        finish_frame("t6", ramp_up, 3000, qb, rb, db);

        check("tx_int_fell_while_busy", fall_busy_err, 0);
        check("tx_data_unstable", stab_err, 0);
        check("done_wider_than_1", done_wide_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
